serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the existing single-bit full_adder cell, with one carry flop feeding the cell's carry input.
- Accepts two parallel operands and a carry-in on a start strobe, then adds LSB-first at one bit per clock.
- Presents the parallel sum and carry-out with a one-cycle done pulse.
- It is the sequential stage that drives full_adder in the datapath: a low-area alternative to a ripple adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while an addition is in progress (RUN)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result of a+b+cin, low WIDTH bits
- cout  output  1  registered carry-out (bit WIDTH of a+b+cin)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0; operand shift registers, carry flop and bit counter all cleared. Any addition in progress is abandoned and no done pulse is produced for it.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE, start=1 at edge k:
  - load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, clear the partial-sum shift register;
  - go to RUN.
- RUN, every edge:
  - full_adder inputs are a_sr[0], b_sr[0], carry;
  - the sum bit shifts into the partial-sum register at the MSB, shifting right;
  - a_sr and b_sr shift right; carry<=full_adder carry; cnt<=cnt+1.
- RUN, edge where cnt==WIDTH-1 (edge k+WIDTH):
  - sum<=completed partial-sum value including this bit; cout<=this bit's carry;
  - go to DONE.
- Latency: done is high for exactly the one cycle after edge k+WIDTH, i.e. the result is valid WIDTH cycles after the start edge.
- DONE, next edge:
  - start=1: accepted exactly as from IDLE (load, go to RUN). Back-to-back additions cost no idle cycle.
  - start=0: go to IDLE.
- start while in RUN is ignored; operands and carry-in presented then are not captured.
- sum and cout change only at a completion edge or reset. They hold the last result through IDLE and through the whole of the next RUN.
- Changes on a, b and cin after start has been accepted have no effect.
- WIDTH=1: RUN lasts one edge, so done follows start by one cycle.
- cnt is $clog2(WIDTH)+1 bits wide and never wraps within an operation.

Decomposition:
- Package serial_adder_pkg holds the state enum (IDLE, RUN, DONE) as a 2-bit typedef, plus a localparam helper for the counter width.
- Sub-module: instantiate the existing full_adder (ports a, b, c, carry, sum) once for the bit-slice.
- The FSM, shift registers and carry flop stay in serial_adder.

Test Plan (WIDTH=8 unless stated):
- a=0x00, b=0x00, cin=0, start pulse -> busy high for 8 cycles; done pulses in the 8th cycle after start; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 issued in the DONE cycle -> no idle gap; sum=0x00, cout=1.
- During RUN, start=1 with a=0x11, b=0x22 -> ignored; the in-flight 0x0F+0x01 result, sum=0x10 and cout=0, is unaffected.
- rst_n low in the 4th RUN cycle, then released -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse follows. A fresh 0x80+0x80 then gives sum=0x00, cout=1.
- Exhaustive with WIDTH=2: all 32 combinations of a, b and cin compared against a+b+cin in a reference model; done follows start by exactly 2 cycles every time.
- WIDTH=1: a=1, b=1, cin=1 -> done one cycle after start; sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One spare bit so the bit counter never wraps inside an operation.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial adder's bit-slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic carry,
    output logic sum
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full_adder slice plus a carry flop, LSB first,
// one bit per clock, with a registered parallel result and a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  psum_q, psum_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic              fa_sum;
    logic              fa_carry;
    logic [WIDTH-1:0]  psum_shift;

    full_adder u_full_adder (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (carry_q),
        .carry (fa_carry),
        .sum   (fa_sum)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    generate
        if (WIDTH == 1) begin : g_psum_w1
            assign psum_shift = fa_sum;
        end else begin : g_psum_wn
            assign psum_shift = {fa_sum, psum_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                psum_d  = psum_shift;
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = psum_shift;
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 2 and 1.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       s8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       s2, c2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic       s1, c1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_checks;
    int n_errors;
    int lat;
    int busy_n;
    int done_n;
    logic [2:0] ref2;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2), .cin(c2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents an 8-bit operation for one edge; returns at the first RUN negedge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    // Samples at negedges until done8, counting cycles since the start edge.
    task automatic wait8(input int lat0, output int l, output int nb);
        l  = lat0;
        nb = 0;
        while (!done8 && l < 20) begin
            if (busy8) nb++;
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        s8 = 0; a8 = '0; b8 = '0; c8 = 0;
        s2 = 0; a2 = '0; b2 = '0; c2 = 0;
        s1 = 0; a1 = '0; b1 = '0; c1 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_sum",  sum8,  8'h00);
        check("rst_cout", cout8, 1'b0);
        rst_n = 1'b1;

        // 0 + 0 + 0: busy for eight cycles, done in the eighth.
        start8(8'h00, 8'h00, 1'b0);
        wait8(0, lat, busy_n);
        $display("txn w8 a=00 b=00 cin=0 sum=%02h cout=%0d lat=%0d", sum8, cout8, lat);
        check("zero_lat",  lat,    8);
        check("zero_busy", busy_n, 8);
        check("zero_sum",  sum8,   8'h00);
        check("zero_cout", cout8,  1'b0);
        @(negedge clk);
        check("zero_pulse", done8, 1'b0);

        // FF + 01, then A5 + 5A + 1 issued in the DONE cycle.
        start8(8'hFF, 8'h01, 1'b0);
        wait8(0, lat, busy_n);
        $display("txn w8 a=ff b=01 cin=0 sum=%02h cout=%0d lat=%0d", sum8, cout8, lat);
        check("ff01_lat",  lat,   8);
        check("ff01_sum",  sum8,  8'h00);
        check("ff01_cout", cout8, 1'b1);
        a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        a8 = 8'h77; b8 = 8'h99; c8 = 1'b0;
        check("b2b_nogap", busy8, 1'b1);
        check("b2b_hold",  {cout8, sum8}, 9'h100);
        wait8(0, lat, busy_n);
        $display("txn w8 a=a5 b=5a cin=1 sum=%02h cout=%0d lat=%0d", sum8, cout8, lat);
        check("a55a_lat",  lat,   8);
        check("a55a_sum",  sum8,  8'h00);
        check("a55a_cout", cout8, 1'b1);

        // Start during RUN is ignored.
        @(negedge clk);
        start8(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; c8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        check("ign_hold", {cout8, sum8}, 9'h100);
        wait8(4, lat, busy_n);
        $display("txn w8 a=0f b=01 cin=0 sum=%02h cout=%0d lat=%0d", sum8, cout8, lat);
        check("ign_lat",  lat,   8);
        check("ign_sum",  sum8,  8'h10);
        check("ign_cout", cout8, 1'b0);
        @(negedge clk);
        check("ign_idle", {busy8, done8}, 2'b00);

        // Asynchronous reset in the fourth RUN cycle.
        start8(8'h33, 8'h44, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 1'b0);
        check("arst_done", done8, 1'b0);
        check("arst_sum",  sum8,  8'h00);
        check("arst_cout", cout8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) done_n++;
        end
        $display("txn w8 reset-abandoned done_pulses=%0d", done_n);
        check("arst_nodone", done_n, 0);
        start8(8'h80, 8'h80, 1'b0);
        wait8(0, lat, busy_n);
        $display("txn w8 a=80 b=80 cin=0 sum=%02h cout=%0d lat=%0d", sum8, cout8, lat);
        check("8080_lat",  lat,   8);
        check("8080_sum",  sum8,  8'h00);
        check("8080_cout", cout8, 1'b1);

        // WIDTH=2 exhaustive against a + b + cin.
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a2 = 2'(ia); b2 = 2'(ib); c2 = 1'(ic); s2 = 1'b1;
                    @(negedge clk);
                    s2 = 1'b0;
                    lat = 0;
                    while (!done2 && lat < 20) begin
                        @(negedge clk);
                        lat++;
                    end
                    ref2 = 3'(ia + ib + ic);
                    $display("txn w2 a=%0d b=%0d cin=%0d sum=%0d cout=%0d lat=%0d",
                             ia, ib, ic, sum2, cout2, lat);
                    check("w2_lat", lat, 2);
                    check("w2_res", {cout2, sum2}, ref2);
                end
            end
        end

        // WIDTH=1.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        check("w1_done", done1, 1'b0);
        @(negedge clk);
        $display("txn w1 a=1 b=1 cin=1 sum=%0d cout=%0d done=%0d", sum1, cout1, done1);
        check("w1_done1", done1, 1'b1);
        check("w1_res",   {cout1, sum1}, 2'b11);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        @(negedge clk);
        $display("txn w1 a=1 b=0 cin=0 sum=%0d cout=%0d done=%0d", sum1, cout1, done1);
        check("w1b_done", done1, 1'b1);
        check("w1b_res",  {cout1, sum1}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
